// File: rtl/tdm_demux_defs_pkg.sv
// Shared definitions for the TDM demultiplexer.
// Optional build macro TDM_DEMUX_PARITY_EN adds a fifth (even parity) slot to
// every frame and widens the slot counter to 3 bits.
package tdm_demux_defs_pkg;

  localparam int unsigned NUM_CHANNELS = 4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned SLOTS_PER_FRAME = 5;
  localparam int unsigned SLOT_W          = 3;
`else
  localparam int unsigned SLOTS_PER_FRAME = 4;
  localparam int unsigned SLOT_W          = 2;
`endif

  // Frame alignment state
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/channel_shift_reg.sv
// Per-channel serial-to-parallel shift register, MSB first.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   shift_en   : shift din into the LSB this cycle
//   clear      : zero the register; with shift_en the result is just din
//   din        : serial bit
//   q          : parallel contents
module channel_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // Clear-with-shift restarts the word with din as its first (MSB-to-be) bit
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= shift_en ? WIDTH'(din) : '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/tdm_demultiplexer.sv
// TDM demultiplexer: rebuilds four WIDTH-bit channel words from one serial
// stream of bit-interleaved frames (one bit per channel per frame, MSB first).
// Optional build macro: TDM_DEMUX_PARITY_EN (5-slot frames with even parity
// in slot 4, adds the parity_err output).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   din, din_valid    : serial bit and its qualifier
//   frame_sync        : marks slot 0 of the first frame of a word set
//   out0..out3        : registered channel words, held until next completion
//   out_valid         : one-cycle pulse when out0..out3 are loaded
//   sync_err          : one-cycle pulse on an alignment violation
//   locked            : high while aligned (RUN)
//   parity_err        : (parity build) one-cycle pulse after a bad slot 4
module tdm_demultiplexer
  import tdm_demux_defs_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  output logic             sync_err,
  output logic             locked
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int unsigned         BIT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SLOT_W-1:0]   LAST_SLOT = SLOT_W'(SLOTS_PER_FRAME - 1);
  localparam logic [BIT_W-1:0]    LAST_BIT  = BIT_W'(WIDTH - 1);

  state_e            state_q;
  logic [SLOT_W-1:0] slot_cnt;
  logic [BIT_W-1:0]  bit_cnt;

  logic fresh_c;     // beat starts a new word set at slot 0
  logic normal_c;    // beat continues the current word set
  logic missing_c;   // expected frame_sync absent
  logic stray_c;     // frame_sync in the wrong place
  logic complete_c;  // final beat of a word set
  logic drop_set_c;  // completed set must not be published

  logic [NUM_CHANNELS-1:0] shift_en_c;
  logic [WIDTH-1:0]        sr_q   [NUM_CHANNELS];
  logic [WIDTH-1:0]        word_c [NUM_CHANNELS];

`ifdef TDM_DEMUX_PARITY_EN
  logic par_q;        // running parity over slots 0..3 of the current frame
  logic bad_q;        // a parity failure has hit the current word set
  logic par_mismatch_c;
`endif

  // Beat classification, shift enables and the words as they will be after this beat
  always_comb begin
    fresh_c    = 1'b0;
    normal_c   = 1'b0;
    missing_c  = 1'b0;
    stray_c    = 1'b0;
    if (din_valid) begin
      if (state_q == ST_HUNT) begin
        fresh_c = frame_sync;
      end else if (slot_cnt == SLOT_W'(0) && bit_cnt == BIT_W'(0)) begin
        normal_c  = frame_sync;
        missing_c = ~frame_sync;
      end else if (frame_sync) begin
        stray_c = 1'b1;
        fresh_c = 1'b1;
      end else begin
        normal_c = 1'b1;
      end
    end
    complete_c = normal_c && (slot_cnt == LAST_SLOT) && (bit_cnt == LAST_BIT);

    for (int n = 0; n < NUM_CHANNELS; n++) begin
      shift_en_c[n] = (fresh_c && n == 0) || (normal_c && slot_cnt == SLOT_W'(n));
      word_c[n]     = shift_en_c[n] ? {sr_q[n][WIDTH-2:0], din} : sr_q[n];
    end

`ifdef TDM_DEMUX_PARITY_EN
    par_mismatch_c = normal_c && (slot_cnt == LAST_SLOT) && (din != par_q);
    drop_set_c     = bad_q || par_mismatch_c;
`else
    drop_set_c     = 1'b0;
`endif
  end

  // Four channel shift registers; a fresh start wipes any partial words
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    channel_shift_reg #(.WIDTH(WIDTH)) u_sr (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en_c[g]),
      .clear    (fresh_c),
      .din      (din),
      .q        (sr_q[g])
    );
  end

  // Alignment FSM, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      slot_cnt  <= '0;
      bit_cnt   <= '0;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      locked    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_q      <= 1'b0;
      bad_q      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (missing_c) begin
        sync_err <= 1'b1;
        state_q  <= ST_HUNT;
        locked   <= 1'b0;
        slot_cnt <= '0;
        bit_cnt  <= '0;
      end else if (fresh_c) begin
        sync_err <= stray_c;
        state_q  <= ST_RUN;
        locked   <= 1'b1;
        slot_cnt <= SLOT_W'(1);
        bit_cnt  <= '0;
`ifdef TDM_DEMUX_PARITY_EN
        par_q    <= din;
        bad_q    <= 1'b0;
`endif
      end else if (normal_c) begin
        if (slot_cnt == LAST_SLOT) begin
          slot_cnt <= '0;
          bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
        end else begin
          slot_cnt <= slot_cnt + SLOT_W'(1);
        end
`ifdef TDM_DEMUX_PARITY_EN
        par_q      <= (slot_cnt == SLOT_W'(0)) ? din : (par_q ^ din);
        parity_err <= par_mismatch_c;
        bad_q      <= complete_c ? 1'b0 : (bad_q | par_mismatch_c);
`endif
        if (complete_c && !drop_set_c) begin
          out0      <= word_c[0];
          out1      <= word_c[1];
          out2      <= word_c[2];
          out3      <= word_c[3];
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Randomized scoreboard bench for tdm_demultiplexer (WIDTH=8).
module tb_tdm_demultiplexer;

  localparam int unsigned W = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned SLOTS = 5;
`else
  localparam int unsigned SLOTS = 4;
`endif
  localparam int unsigned NBEATS = W * SLOTS;

  typedef logic [3:0][W-1:0] words_t;
  typedef struct packed {
    words_t      w;
    logic [31:0] cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, din, din_valid, frame_sync;
  logic [W-1:0] out0, out1, out2, out3;
  logic         out_valid, sync_err, locked;
`ifdef TDM_DEMUX_PARITY_EN
  logic         parity_err;
`endif

  tdm_demultiplexer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out_valid  (out_valid),
    .sync_err   (sync_err),
    .locked     (locked)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  exp_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   sync_seen  = 0;
  int   exp_sync   = 0;
  int   par_seen   = 0;
  int   exp_par    = 0;
  words_t last_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected word set
  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_valid: got out_valid=1 with words %h, expected no word set",
                 {out3, out2, out1, out0});
      end else begin
        e = expq.pop_front();
        check("out_words", {out3, out2, out1, out0}, 64'(e.w));
        check("valid_latency", 64'(cyc), 64'(e.cyc));
      end
    end
    if (sync_err === 1'b1) sync_seen++;
`ifdef TDM_DEMUX_PARITY_EN
    if (parity_err === 1'b1) par_seen++;
`endif
  end

  function automatic words_t mk(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic words_t rnd_words();
    return words_t'({$urandom, $urandom});
  endfunction

  // Reference serialiser: frame f carries bit W-1-f of each channel, then parity
  function automatic logic beat_bit(input words_t w, input int f, input int s);
    logic [3:0] b;
    for (int c = 0; c < 4; c++) b[c] = w[c][W-1-f];
    if (s < 4) return b[s];
    return ^b;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      din        = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Send the first nb beats of a word set with ngaps random invalid cycles inserted
  task automatic send_set(input words_t w, input bit sync_first, input int ngaps,
                          input int flip_frame, input bit expect_ok, input int nb,
                          input bit chk_lock);
    int   gap_at[NBEATS];
    exp_t e;
    foreach (gap_at[i]) gap_at[i] = 0;
    for (int g = 0; g < ngaps; g++) gap_at[$urandom_range(1, nb - 1)]++;
    for (int k = 0; k < nb; k++) begin
      for (int g = 0; g < gap_at[k]; g++) begin
        @(negedge clk);
        din_valid  = 1'b0;
        din        = 1'($urandom);
        frame_sync = 1'($urandom);
      end
      @(negedge clk);
      if (chk_lock && k == 1) check("locked_after_sync", 64'(locked), 64'd1);
      din = beat_bit(w, k / int'(SLOTS), k % int'(SLOTS));
      if ((k % int'(SLOTS)) == 4 && (k / int'(SLOTS)) == flip_frame) din = ~din;
      frame_sync = (k == 0) && sync_first;
      din_valid  = 1'b1;
      if (expect_ok && k == nb - 1) begin
        e.w   = w;
        e.cyc = 32'(cyc + 1);
        expq.push_back(e);
        last_w = w;
      end
    end
  endtask

  initial begin
    words_t w;
    reset      = 1'b1;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    last_w     = '0;
    repeat (3) @(negedge clk);
    check("reset_words", {out3, out2, out1, out0}, 64'd0);
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_sync_err", 64'(sync_err), 64'd0);
    reset = 1'b0;

    // Aligned set, then the same set with three dead cycles mid-stream
    send_set(mk(8'hA5, 8'h3C, 8'hFF, 8'h00), 1, 0, -1, 1, NBEATS, 1);
    idle(3);
    send_set(mk(8'hA5, 8'h3C, 8'hFF, 8'h00), 1, 3, -1, 1, NBEATS, 0);
    idle(3);

    // Reset mid-word drops everything
    send_set(rnd_words(), 1, 0, -1, 0, 10, 0);
    do_reset();
    check("midword_reset_words", {out3, out2, out1, out0}, 64'd0);
    check("midword_reset_locked", 64'(locked), 64'd0);
    last_w = '0;

    // Beats without frame_sync in HUNT are ignored
    send_set(rnd_words(), 0, 0, -1, 0, 5, 0);
    idle(1);
    check("hunt_locked", 64'(locked), 64'd0);
    check("hunt_no_sync_err", 64'(sync_seen), 64'(exp_sync));
    send_set(mk(8'h12, 8'h34, 8'h56, 8'h78), 1, 0, -1, 1, NBEATS, 1);

    // Stray frame_sync at frame 3 slot 2 restarts the set
    send_set(rnd_words(), 1, 0, -1, 0, 3 * SLOTS + 2, 0);
    exp_sync++;
    send_set(mk(8'h01, 8'h02, 8'h03, 8'h04), 1, 0, -1, 1, NBEATS, 0);
    idle(3);
    check("stray_sync_err", 64'(sync_seen), 64'(exp_sync));

    // Missing frame_sync on a back-to-back set drops lock and holds outputs
    w = rnd_words();
    send_set(w, 1, 0, -1, 1, NBEATS, 0);
    send_set(rnd_words(), 0, 0, -1, 0, NBEATS, 0);
    exp_sync++;
    idle(2);
    check("missing_sync_locked", 64'(locked), 64'd0);
    check("missing_sync_hold", {out3, out2, out1, out0}, 64'(w));
    check("missing_sync_err", 64'(sync_seen), 64'(exp_sync));

    // Random sets with random dead cycles and occasional HUNT noise
    for (int r = 0; r < 6; r++) begin
      if (r == 0) send_set(rnd_words(), 0, 0, -1, 0, $urandom_range(2, 7), 0);
      send_set(rnd_words(), 1, $urandom_range(0, 4), -1, 1, NBEATS, 0);
    end
    idle(2);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity in frame 5 suppresses the set; a clean set then goes through
    send_set(rnd_words(), 1, 0, 5, 0, NBEATS, 0);
    exp_par++;
    idle(2);
    check("parity_hold", {out3, out2, out1, out0}, 64'(last_w));
    check("parity_err_count", 64'(par_seen), 64'(exp_par));
    send_set(mk(8'hC3, 8'h81, 8'h7E, 8'h5A), 1, 0, -1, 1, NBEATS, 0);
    idle(2);
    check("parity_clean_words", {out3, out2, out1, out0}, 64'(mk(8'hC3, 8'h81, 8'h7E, 8'h5A)));
`endif

    idle(5);
    check("pending_expect", 64'(expq.size()), 64'd0);
    check("sync_err_total", 64'(sync_seen), 64'(exp_sync));
    check("parity_err_total", 64'(par_seen), 64'(exp_par));
    check("final_words", {out3, out2, out1, out0}, 64'(last_w));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
